pipeline_run_ctrl: RTL and testbench

Run/step/halt sequencer for the 5-stage MIPS pipeline under debug control. Accepts commands from the debug link (UART command decoder), drives the pipeline-wide advance enable (`i_step` of every stage) and the front-end hold, and detects the HALT word (`0xFFFFFFFF`) flagged by the decode stage. After HALT it drains the back end. It also sequences a read-out of all 32 general registers through the register file's debug read port.

---
 rtl/mips_dbg_pkg.sv | 11 +
 rtl/regfile_dump_seq.sv | 41 ++++
 rtl/pipeline_run_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_run_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: debug-control states, command codes and HALT word shared across the pipeline
package mips_dbg_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_STEP, ST_DRAIN, ST_HALTED, ST_DUMP_RD, ST_DUMP_OUT
  } state_t;
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/regfile_dump_seq.sv
// regfile_dump_seq: walks the register file debug port, presenting one captured word at a time
module regfile_dump_seq #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               capture,
  input  logic               ready,
  input  logic [NB_DATA-1:0] rd_data,
  output logic [NB_ADDR-1:0] addr,
  output logic               valid,
  output logic               last,
  output logic [NB_DATA-1:0] data,
  output logic               word_done,
  output logic               dump_done
);
  assign word_done = valid & ready;
  assign dump_done = word_done & last;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (start) begin
      addr  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (capture) begin
      data  <= rd_data;
      valid <= 1'b1;
      last  <= &addr;
    end else if (word_done) begin
      valid <= 1'b0;
      last  <= 1'b0;
      addr  <= last ? addr : addr + NB_ADDR'(1);
    end
  end
endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/halt sequencer with post-HALT drain and register dump
module pipeline_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt,
  output logic               o_step,
  output logic               o_front_hold,
  output logic               o_halted,
  output logic               o_busy,
  output logic [NB_ADDR-1:0] o_dbg_rd_addr,
  input  logic [NB_DATA-1:0] i_dbg_rd_data,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic [31:0]        o_cycle_count
);
  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);
  state_t state, state_d;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic [31:0] cycle_q;
  logic ret_halted, accept, start, capture, word_done, dump_done, in_dump;
  assign o_cmd_ready   = state == ST_IDLE || state == ST_HALTED;
  assign o_step        = state == ST_RUN || state == ST_STEP || state == ST_DRAIN;
  assign in_dump       = state == ST_DUMP_RD || state == ST_DUMP_OUT;
  assign o_front_hold  = state == ST_DRAIN || state == ST_HALTED || (in_dump && ret_halted);
  assign o_dbg_rd_addr = capture ? o_dump_addr : '0;
  assign o_cycle_count = cycle_q;
  assign accept        = i_cmd_valid & o_cmd_ready;
  assign start         = accept && i_cmd == CMD_DUMP;
  assign capture       = state == ST_DUMP_RD;
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:     if (accept) state_d = i_cmd == CMD_RUN  ? ST_RUN :
                                         i_cmd == CMD_STEP ? ST_STEP :
                                         i_cmd == CMD_DUMP ? ST_DUMP_RD : ST_IDLE;
      ST_RUN:      if (i_halt) state_d = ST_DRAIN;
      ST_STEP:     state_d = i_halt ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:    if (drain_cnt == NB_DRAIN'(1)) state_d = ST_HALTED;
      ST_HALTED:   if (start) state_d = ST_DUMP_RD;
      ST_DUMP_RD:  state_d = ST_DUMP_OUT;
      ST_DUMP_OUT: state_d = dump_done ? (ret_halted ? ST_HALTED : ST_IDLE) :
                             word_done ? ST_DUMP_RD : ST_DUMP_OUT;
      default:     state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      ret_halted <= 1'b0;
      o_halted   <= 1'b0;
      o_busy     <= 1'b0;
      cycle_q    <= '0;
    end else begin
      state      <= state_d;
      drain_cnt  <= (state_d == ST_DRAIN && state != ST_DRAIN) ? NB_DRAIN'(DRAIN_CYCLES)
                                                               : drain_cnt - NB_DRAIN'(state == ST_DRAIN);
      ret_halted <= start ? state == ST_HALTED : ret_halted;
      o_halted   <= state_d == ST_HALTED;
      o_busy     <= !(state_d == ST_IDLE || state_d == ST_HALTED);
      if (o_step && !(&cycle_q)) cycle_q <= cycle_q + 32'd1;
    end
  end
  regfile_dump_seq #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_dump (
    .clk       (clk),
    .rst       (i_reset),
    .start     (start),
    .capture   (capture),
    .ready     (i_dump_ready),
    .rd_data   (i_dbg_rd_data),
    .addr      (o_dump_addr),
    .valid     (o_dump_valid),
    .last      (o_dump_last),
    .data      (o_dump_data),
    .word_done (word_done),
    .dump_done (dump_done)
  );
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: randomized transaction-level checks of run/step/halt/dump sequencing
module tb_pipeline_run_ctrl;
  localparam int DRAIN = 4;
  logic clk = 1'b0, i_reset = 1'b1, i_cmd_valid = 1'b0, i_halt = 1'b0, i_dump_ready = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic o_cmd_ready, o_step, o_front_hold, o_halted, o_busy, o_dump_valid, o_dump_last;
  logic [4:0] o_dbg_rd_addr, o_dump_addr;
  logic [31:0] i_dbg_rd_data, o_dump_data, o_cycle_count, exp_cnt;
  logic [31:0] rf [32];
  logic [37:0] words [$];
  int n_cmp = 0, n_err = 0, n_step = 0, n_hold = 0, n_busy = 0;
  always #5 clk = ~clk;
  assign i_dbg_rd_data = rf[o_dbg_rd_addr];
  pipeline_run_ctrl dut (
    .clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .o_step(o_step), .o_front_hold(o_front_hold),
    .o_halted(o_halted), .o_busy(o_busy), .o_dbg_rd_addr(o_dbg_rd_addr),
    .i_dbg_rd_data(i_dbg_rd_data), .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr),
    .o_dump_data(o_dump_data), .o_dump_last(o_dump_last), .i_dump_ready(i_dump_ready),
    .o_cycle_count(o_cycle_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
    logic [32:0] s;
    s = {1'b0, a} + 33'(n);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
  task automatic cycle();
    #1;
    n_step += int'(o_step);
    n_hold += int'(o_front_hold);
    n_busy += int'(o_busy);
    if (o_dump_valid && i_dump_ready) words.push_back({o_dump_last, o_dump_addr, o_dump_data});
    @(negedge clk);
  endtask
  task automatic clear();
    n_step = 0; n_hold = 0; n_busy = 0;
    words.delete();
  endtask
  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    for (int i = 0; i < 300 && !o_cmd_ready; i++) cycle();
    chk("cmd_ready_wait", o_cmd_ready, 1);
    cycle();
    i_cmd_valid = 1'b0;
    i_cmd = 2'b00;
  endtask
  task automatic do_reset();
    i_reset = 1'b1; i_halt = 1'b0; i_cmd_valid = 1'b0; i_dump_ready = 1'b0;
    cycle();
    i_reset = 1'b0;
    exp_cnt = '0;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_step", o_step, 0);
    chk("rst_front_hold", o_front_hold, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_dump_valid", o_dump_valid, 0);
    chk("rst_dump_last", o_dump_last, 0);
    chk("rst_dump_addr", o_dump_addr, 0);
    chk("rst_dump_data", o_dump_data, 0);
    chk("rst_rd_addr", o_dbg_rd_addr, 0);
    chk("rst_count", o_cycle_count, 0);
  endtask
  task automatic step_test(input int k);
    for (int s = 0; s < k; s++) begin
      clear();
      send(2'b10);
      chk("step_pulse", o_step, 1);
      cycle();
      exp_cnt = sat_add(exp_cnt, 1);
      chk("step_after", o_step, 0);
      chk("step_back_idle", o_cmd_ready, 1);
      chk("step_busy", o_busy, 0);
      chk("step_pulses", n_step, 1);
      chk("step_count", o_cycle_count, exp_cnt);
    end
  endtask
  task automatic run_halt(input int len);
    clear();
    send(2'b01);
    repeat (len - 1) cycle();
    i_halt = 1'b1;
    cycle();
    for (int d = 0; d < DRAIN; d++) begin
      chk("drain_outputs", {o_step, o_front_hold, o_halted}, 3'b110);
      cycle();
    end
    exp_cnt = sat_add(exp_cnt, len + DRAIN);
    chk("halt_flag", o_halted, 1);
    chk("halt_step", o_step, 0);
    chk("halt_hold", o_front_hold, 1);
    chk("halt_busy", o_busy, 0);
    chk("run_steps", n_step, len + DRAIN);
    chk("run_hold_cycles", n_hold, DRAIN);
    chk("run_count", o_cycle_count, exp_cnt);
  endtask
  task automatic halted_cmds();
    for (int j = 0; j < 3; j++) begin
      send(j == 2 ? 2'b00 : (j == 0 ? 2'b01 : 2'b10));
      cycle();
      chk("hcmd_step", o_step, 0);
      chk("hcmd_halted", o_halted, 1);
      chk("hcmd_ready", o_cmd_ready, 1);
      chk("hcmd_count", o_cycle_count, exp_cnt);
    end
  endtask
  task automatic dump_test(input int mode, input bit ret_halted);
    logic [37:0] w;
    send(2'b11);
    clear();
    i_dump_ready = 1'b1;
    for (int i = 0; i < 600 && !o_cmd_ready; i++) begin
      i_dump_ready = mode == 0 ? 1'b1 : mode == 1 ? ~i_dump_ready : 1'($urandom);
      cycle();
    end
    i_dump_ready = 1'b0;
    chk("dump_returned", o_cmd_ready, 1);
    chk("dump_words", words.size(), 32);
    for (int i = 0; i < 32 && i < words.size(); i++) begin
      w = words[i];
      chk("dump_addr", w[36:32], i);
      chk("dump_data", w[31:0], rf[i]);
      chk("dump_last", w[37], i == 31);
    end
    chk("dump_no_step", n_step, 0);
    chk("dump_hold", n_hold, ret_halted ? n_busy : 0);
    if (mode == 0) chk("dump_cycles", n_busy, 64);
    chk("dump_ret_halted", o_halted, ret_halted);
    chk("dump_count", o_cycle_count, exp_cnt);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
    @(negedge clk);
    do_reset();
    for (int it = 0; it < 3; it++) begin
      step_test(it == 0 ? 3 : $urandom_range(1, 4));
      run_halt(it == 0 ? 10 : $urandom_range(1, 20));
      halted_cmds();
      dump_test(it == 0 ? 1 : 2, 1'b1);
      do_reset();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
    end
    dump_test(0, 1'b0);
    rf[7] = rf[7] | 32'h1;
    send(2'b11);
    i_dump_ready = 1'b1;
    for (int i = 0; i < 200 && !(o_dump_valid && o_dump_addr == 5'd7); i++) cycle();
    chk("mid_dump_at7", {o_dump_valid, o_dump_addr}, {1'b1, 5'd7});
    do_reset();
    send(2'b01);
    repeat (2) cycle();
    i_halt = 1'b1;
    repeat (2) cycle();
    chk("mid_drain_hold", o_front_hold, 1);
    do_reset();
    force dut.cycle_q = 32'hFFFF_FFFE;
    cycle();
    release dut.cycle_q;
    exp_cnt = 32'hFFFF_FFFE;
    chk("sat_preload", o_cycle_count, exp_cnt);
    send(2'b01);
    repeat (5) cycle();
    exp_cnt = sat_add(exp_cnt, 6);
    chk("sat_hold", o_cycle_count, exp_cnt);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
